// File: rtl/spi_pkg.sv
// Shared types and mode-0 constants for the SPI peripheral.
// Bits travel MSB first; sck idles low (CPOL=0), data sampled on rising sck (CPHA=0).
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE_WAIT
    } spi_periph_state_t;

    // Mode 0 idle level of sck, used as the synchronizer reset value.
    localparam logic SCK_IDLE = 1'b0;

    // cs synchronizer resets high so a cs held high through reset never looks like a new frame.
    localparam logic CS_RST_LEVEL = 1'b1;

endpackage

// File: rtl/spi_sync.sv
// STAGES-deep synchronizer for an asynchronous pin, with rise/fall detect
// taken from the last two synchronized samples.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic nrst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_p;
    logic              prev_p;
    logic              q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_p <= {STAGES{RST_VAL}};
            prev_p <= RST_VAL;
        end else begin
            sync_p <= (sync_p << 1) | STAGES'(din);
            prev_p <= sync_p[STAGES-1];
        end
    end

    assign q    = sync_p[STAGES-1];
    assign rise = q & ~prev_p;
    assign fall = ~q & prev_p;

endmodule

// File: rtl/spi_peripheral.sv
// Mode-0 SPI responder oversampled in the clk domain; one RX word and one TX word per frame.
// Optional sticky frame-error flag enabled by defining SPI_PERIPHERAL_ERR_EN.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int TX_WIDTH    = 8,
    parameter int RX_WIDTH    = 8,
    parameter int NSCK        = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                sck,
    input  logic                sdi,
    input  logic                cs,
    output logic                sdo,
    input  logic [TX_WIDTH-1:0] tx_data,
    output logic [RX_WIDTH-1:0] rx_data,
    output logic                done
`ifdef SPI_PERIPHERAL_ERR_EN
    ,
    output logic                err
`endif
);

    localparam int CNT_W = $clog2(NSCK + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NSCK - 1);

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] sdi_p;
    logic sdi_s;

    spi_periph_state_t state, state_nxt;
    logic [TX_WIDTH-1:0] tx_shift, tx_shift_nxt, tx_shifted;
    logic [RX_WIDTH-1:0] rx_shift, rx_shift_nxt, rx_shifted;
    logic [RX_WIDTH-1:0] rx_data_nxt;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic                sdo_nxt, done_nxt;
`ifdef SPI_PERIPHERAL_ERR_EN
    logic                err_nxt;
`endif

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SCK_IDLE)) u_sck_sync (
        .clk  (clk),
        .nrst (nrst),
        .din  (sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CS_RST_LEVEL)) u_cs_sync (
        .clk  (clk),
        .nrst (nrst),
        .din  (cs),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // sdi only needs the same delay as sck so it lines up with the detected edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) sdi_p <= '0;
        else       sdi_p <= (sdi_p << 1) | SYNC_STAGES'(sdi);
    end
    assign sdi_s = sdi_p[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            rx_data <= '0;
            bit_cnt <= '0;
            sdo     <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            rx_data <= rx_data_nxt;
            bit_cnt <= bit_cnt_nxt;
            sdo     <= sdo_nxt;
            done    <= done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        tx_shift <= tx_shift_nxt;
        rx_shift <= rx_shift_nxt;
    end

`ifdef SPI_PERIPHERAL_ERR_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) err <= 1'b0;
        else       err <= err_nxt;
    end
`endif

    always_comb begin
        state_nxt    = state;
        tx_shift_nxt = tx_shift;
        rx_shift_nxt = rx_shift;
        rx_data_nxt  = rx_data;
        bit_cnt_nxt  = bit_cnt;
        sdo_nxt      = sdo;
        done_nxt     = 1'b0;
`ifdef SPI_PERIPHERAL_ERR_EN
        err_nxt      = err;
`endif
        tx_shifted   = tx_shift << 1;
        rx_shifted   = (rx_shift << 1) | RX_WIDTH'(sdi_s);

        case (state)
            IDLE: begin
                sdo_nxt = 1'b0;
                if (cs_rise) begin
                    tx_shift_nxt = tx_data;
                    sdo_nxt      = tx_data[TX_WIDTH-1];
                    bit_cnt_nxt  = '0;
                    state_nxt    = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cs_fall) begin
                    sdo_nxt   = 1'b0;
                    state_nxt = IDLE;
`ifdef SPI_PERIPHERAL_ERR_EN
                    if (bit_cnt != '0) err_nxt = 1'b1;
`endif
                end else if (sck_rise) begin
                    rx_shift_nxt = rx_shifted;
                    bit_cnt_nxt  = bit_cnt + CNT_W'(1);
                    // Last bit: publish the word in the same clk as the final shift.
                    if (bit_cnt == LAST_BIT) begin
                        rx_data_nxt = rx_shifted;
                        done_nxt    = 1'b1;
                        sdo_nxt     = 1'b0;
                        state_nxt   = DONE_WAIT;
`ifdef SPI_PERIPHERAL_ERR_EN
                        err_nxt     = 1'b0;
`endif
                    end
                end else if (sck_fall) begin
                    tx_shift_nxt = tx_shifted;
                    sdo_nxt      = tx_shifted[TX_WIDTH-1];
                end
            end
            DONE_WAIT: begin
                sdo_nxt = 1'b0;
                if (cs_fall) begin
                    state_nxt = IDLE;
                end
`ifdef SPI_PERIPHERAL_ERR_EN
                else if (sck_rise) begin
                    err_nxt = 1'b1;
                end
`endif
            end
            default: begin
                sdo_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: fixed frame table, random frames against a frame-level model,
// and a mid-frame reset sequence. Error flag checks follow SPI_PERIPHERAL_ERR_EN.
module tb_spi_peripheral;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       sck = 1'b0;
    logic       sdi = 1'b0;
    logic       cs = 1'b0;
    logic       sdo;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       done;
`ifdef SPI_PERIPHERAL_ERR_EN
    logic       err;
    logic       exp_err_m;
`endif

    spi_peripheral #(
        .TX_WIDTH(8), .RX_WIDTH(8), .NSCK(16), .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .sck     (sck),
        .sdi     (sdi),
        .cs      (cs),
        .sdo     (sdo),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .done    (done)
`ifdef SPI_PERIPHERAL_ERR_EN
        ,
        .err     (err)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int double_cnt = 0;
    logic done_prev = 1'b0;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (done && done_prev) double_cnt <= double_cnt + 1;
        done_prev <= done;
    end

    typedef struct {
        logic [7:0]  tx;
        logic [15:0] sdi_w;
        int          n;
        bit          chg;
        logic [7:0]  new_tx;
        logic [7:0]  exp_rx;
        int          exp_done;
        logic [31:0] exp_sdo;
        bit          exp_err;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Controller side of one frame: n sck pulses, sdi bits MSB first from sdi_w, then cs drop.
    task automatic run_frame(input logic [7:0] tx, input logic [15:0] sdi_w, input int n,
                             input bit chg, input logic [7:0] new_tx,
                             output logic [31:0] cap);
        cap = '0;
        tx_data = tx;
        cs = 1'b1;
        tick(6);
        for (int k = 0; k < n; k++) begin
            sdi = (k < 16) ? sdi_w[15-k] : 1'b0;
            tick(4);
            cap = (cap << 1) | {31'b0, sdo};
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
            if (chg && k == 1) tx_data = new_tx;
        end
        tick(4);
        cs = 1'b0;
        tick(6);
    endtask

    function automatic logic [31:0] model_sdo(input logic [7:0] tx, input int n);
        logic [31:0] r = '0;
        for (int k = 0; k < n; k++)
            r = (r << 1) | {31'b0, (k < 8) ? tx[7-k] : 1'b0};
        return r;
    endfunction

    logic [7:0]  exp_rx_m;
    logic [31:0] cap;
    int          d0;

    initial begin
        tbl[0] = '{8'hA5, 16'hC33C, 16, 1'b0, 8'h00, 8'h3C, 1, 32'h0000A500, 1'b0};
        tbl[1] = '{8'h12, 16'hFFFF,  5, 1'b0, 8'h00, 8'h3C, 0, 32'h00000002, 1'b1};
        tbl[2] = '{8'hFF, 16'h0081, 16, 1'b0, 8'h00, 8'h81, 1, 32'h0000FF00, 1'b0};
        tbl[3] = '{8'h00, 16'h127E, 16, 1'b0, 8'h00, 8'h7E, 1, 32'h00000000, 1'b0};
        tbl[4] = '{8'h3C, 16'h00E7, 19, 1'b0, 8'h00, 8'hE7, 1, 32'h0001E000, 1'b1};
        tbl[5] = '{8'h99, 16'hAA55, 16, 1'b0, 8'h00, 8'h55, 1, 32'h00009900, 1'b0};
        tbl[6] = '{8'hA5, 16'h0011, 16, 1'b1, 8'h5A, 8'h11, 1, 32'h0000A500, 1'b0};
        tbl[7] = '{8'h5A, 16'h0022, 16, 1'b0, 8'h00, 8'h22, 1, 32'h00005A00, 1'b0};

        tick(3);
        check("reset_sdo", {31'b0, sdo}, 32'd0);
        check("reset_rx", {24'b0, rx_data}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
`ifdef SPI_PERIPHERAL_ERR_EN
        check("reset_err", {31'b0, err}, 32'd0);
`endif
        nrst = 1'b1;
        tick(6);

        for (int i = 0; i < 8; i++) begin
            d0 = done_cnt;
            run_frame(tbl[i].tx, tbl[i].sdi_w, tbl[i].n, tbl[i].chg, tbl[i].new_tx, cap);
            check($sformatf("tbl%0d_rx", i), {24'b0, rx_data}, {24'b0, tbl[i].exp_rx});
            check($sformatf("tbl%0d_done", i), done_cnt - d0, tbl[i].exp_done);
            check($sformatf("tbl%0d_sdo", i), cap, tbl[i].exp_sdo);
            check($sformatf("tbl%0d_sdo_idle", i), {31'b0, sdo}, 32'd0);
`ifdef SPI_PERIPHERAL_ERR_EN
            check($sformatf("tbl%0d_err", i), {31'b0, err}, {31'b0, tbl[i].exp_err});
`endif
        end

        exp_rx_m = 8'h22;
`ifdef SPI_PERIPHERAL_ERR_EN
        exp_err_m = 1'b0;
`endif
        for (int i = 0; i < 40; i++) begin
            logic [7:0]  rtx;
            logic [15:0] rsdi;
            int          rn;
            int          exp_d;
            rtx  = 8'($urandom);
            rsdi = 16'($urandom);
            rn   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
            exp_d = (rn >= 16) ? 1 : 0;
            if (rn >= 16) exp_rx_m = rsdi[7:0];
`ifdef SPI_PERIPHERAL_ERR_EN
            if (rn > 0 && rn < 16) exp_err_m = 1'b1;
            if (rn >= 16) exp_err_m = (rn > 16);
`endif
            d0 = done_cnt;
            run_frame(rtx, rsdi, rn, 1'b0, 8'h00, cap);
            check($sformatf("rnd%0d_rx", i), {24'b0, rx_data}, {24'b0, exp_rx_m});
            check($sformatf("rnd%0d_done", i), done_cnt - d0, exp_d);
            check($sformatf("rnd%0d_sdo", i), cap, model_sdo(rtx, rn));
`ifdef SPI_PERIPHERAL_ERR_EN
            check($sformatf("rnd%0d_err", i), {31'b0, err}, {31'b0, exp_err_m});
`endif
        end

        // Reset in the middle of a frame while cs stays high.
        tx_data = 8'hA5;
        cs = 1'b1;
        tick(6);
        for (int k = 0; k < 7; k++) begin
            sdi = 1'b1;
            tick(4);
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
        end
        tick(2);
        nrst = 1'b0;
        #1;
        check("midrst_sdo", {31'b0, sdo}, 32'd0);
        check("midrst_rx", {24'b0, rx_data}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
`ifdef SPI_PERIPHERAL_ERR_EN
        check("midrst_err", {31'b0, err}, 32'd0);
`endif
        tick(2);
        nrst = 1'b1;
        tick(6);
        d0 = done_cnt;
        for (int k = 0; k < 16; k++) begin
            sdi = 1'b1;
            tick(4);
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
        end
        tick(4);
        check("stale_cs_done", done_cnt - d0, 0);
        check("stale_cs_rx", {24'b0, rx_data}, 32'd0);
        check("stale_cs_sdo", {31'b0, sdo}, 32'd0);
        cs = 1'b0;
        tick(6);
        d0 = done_cnt;
        run_frame(8'hC3, 16'h5542, 16, 1'b0, 8'h00, cap);
        check("post_rst_rx", {24'b0, rx_data}, 32'h42);
        check("post_rst_done", done_cnt - d0, 1);
        check("post_rst_sdo", cap, 32'h0000C300);

        check("done_width", double_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
